prog_data_memory: RTL and testbench

Parametrised single-port data/instruction RAM with a built-in sequential loader. It is the next generation of the processor's 32×32 memory. It adds configurable width and depth, byte-enable writes, and an optional registered read. A post-reset zero-fill sweep and a valid/ready streaming load engine replace the old asynchronous instruction-write strobe, so the host loads programs synchronously before execution.

---
 rtl/prog_data_memory.sv | 116 +++++++++++
 tb/tb_prog_data_memory.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_data_memory.sv
// prog_data_memory: parametrised single-port RAM with byte enables, optional registered read,
// a post-reset zero-fill sweep and a valid/ready sequential load engine.
module prog_data_memory #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int READ_REG = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   data_out,
  output logic                mem_ready,
  output logic                busy,
  input  logic                load_start,
  input  logic [ADDR_W-1:0]   load_base,
  input  logic [ADDR_W:0]     load_count,
  input  logic                load_valid,
  input  logic [DATA_W-1:0]   load_data,
  output logic                load_ready,
  output logic                load_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] LAST = '1;
  typedef enum logic [1:0] {INIT, IDLE, LOAD} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx, wr_addr;
  logic [ADDR_W:0] rem, rem_nx, count_clamped;
  logic done, done_nx, wr_en;
  logic [DATA_W-1:0] wr_data, wr_mask;
  logic [DATA_W-1:0] mem [DEPTH];
  assign count_clamped = load_count > DEPTH_C ? DEPTH_C : load_count;
  assign mem_ready = state == IDLE;
  assign busy = state != IDLE;
  assign load_ready = state == LOAD;
  assign load_done = done;
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    rem_nx = rem;
    done_nx = 1'b0;
    wr_en = 1'b0;
    wr_addr = address;
    wr_data = data;
    wr_mask = '0;
    case (state)
      INIT: begin
        wr_en = 1'b1;
        wr_addr = ptr;
        wr_data = '0;
        wr_mask = '1;
        ptr_nx = ptr + ADDR_W'(1);
        if (ptr == LAST) state_nx = IDLE;
      end
      IDLE: begin
        wr_en = we;
        for (int i = 0; i < NB; i++) wr_mask[8*i +: 8] = {8{be[i]}};
        if (load_start) begin
          if (load_count == '0) done_nx = 1'b1;
          else begin
            state_nx = LOAD;
            ptr_nx = load_base;
            rem_nx = count_clamped;
          end
        end
      end
      LOAD: begin
        if (load_valid) begin
          wr_en = 1'b1;
          wr_addr = ptr;
          wr_data = load_data;
          wr_mask = '1;
          ptr_nx = ptr + ADDR_W'(1);
          rem_nx = rem - ONE_C;
          if (rem == ONE_C) begin
            state_nx = IDLE;
            done_nx = 1'b1;
          end
        end
      end
      default: state_nx = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      ptr <= '0;
      rem <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      rem <= rem_nx;
      done <= done_nx;
    end
  end
  // Masked read-modify-write keeps unselected bytes; reads see the pre-edge word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
  end
  generate
    if (READ_REG != 0) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_out <= '0;
        else data_out <= mem[address];
      end
    end else begin : g_comb
      assign data_out = mem[address];
    end
  endgenerate
endmodule

// File: tb/tb_prog_data_memory.sv
// tb_prog_data_memory: checks a combinational-read and a registered-read instance driven in lockstep.
module tb_prog_data_memory;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] address = '0;
  logic [31:0] data = '0;
  logic we = 1'b0;
  logic [3:0] be = '0;
  logic load_start = 1'b0;
  logic [4:0] load_base = '0;
  logic [5:0] load_count = '0;
  logic load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic [31:0] data_out, data_out_r;
  logic mem_ready, busy, load_ready, load_done;
  logic mem_ready_r, busy_r, load_ready_r, load_done_r;
  int n_chk = 0, n_fail = 0, done_cnt = 0, done_snap;
  logic [31:0] model [32];
  logic [31:0] rq [$];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [31:0] old;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [7];

  prog_data_memory #(.DATA_W(32), .ADDR_W(5), .READ_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data(data), .we(we), .be(be),
    .data_out(data_out), .mem_ready(mem_ready), .busy(busy), .load_start(load_start),
    .load_base(load_base), .load_count(load_count), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_done(load_done));

  prog_data_memory #(.DATA_W(32), .ADDR_W(5), .READ_REG(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .address(address), .data(data), .we(we), .be(be),
    .data_out(data_out_r), .mem_ready(mem_ready_r), .busy(busy_r), .load_start(load_start),
    .load_base(load_base), .load_count(load_count), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready_r), .load_done(load_done_r));

  always #5 clk = ~clk;
  always @(negedge clk) if (load_done) done_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    address = a;
    we = 1'b0;
    #1;
    chk("comb_read", data_out, model[a]);
    rq.push_back(model[a]);
    step();
    chk("reg_read", data_out_r, rq.pop_front());
  endtask

  task automatic init_sweep(input logic drop_test);
    for (int k = 1; k <= 32; k++) begin
      if (drop_test && k == 10) begin
        address = 5'd3; data = '1; be = '1; we = 1'b1;
        load_start = 1'b1; load_base = 5'd3; load_count = 6'd3;
      end
      step();
      if (drop_test && k == 10) begin
        we = 1'b0; load_start = 1'b0;
        chk("init_drop_load_ready", {31'b0, load_ready}, 32'd0);
      end
      chk("init_mem_ready", {31'b0, mem_ready}, {31'b0, k == 32});
      chk("init_mem_ready_r", {31'b0, mem_ready_r}, {31'b0, k == 32});
    end
  endtask

  initial begin
    vecs[0] = '{5'd7,  32'hAABBCCDD, 4'hF, 32'h00000000, 32'hAABBCCDD};
    vecs[1] = '{5'd7,  32'h11223344, 4'h5, 32'hAABBCCDD, 32'hAA22CC44};
    vecs[2] = '{5'd7,  32'h00000000, 4'h0, 32'hAA22CC44, 32'hAA22CC44};
    vecs[3] = '{5'd12, 32'h12345678, 4'h8, 32'h00000000, 32'h12000000};
    vecs[4] = '{5'd12, 32'hFFFFFFFF, 4'h2, 32'h12000000, 32'h1200FF00};
    vecs[5] = '{5'd31, 32'hDEADBEEF, 4'hF, 32'h00000000, 32'hDEADBEEF};
    vecs[6] = '{5'd0,  32'hCAFEF00D, 4'h3, 32'h00000000, 32'h0000F00D};
    foreach (model[i]) model[i] = '0;

    step(); step();
    chk("rst_status", {28'b0, mem_ready, busy, load_ready, load_done}, 32'b0100);
    chk("rst_data_out_r", data_out_r, 32'h0);
    rst_n = 1'b1;
    init_sweep(1'b1);
    for (int a = 0; a < 32; a++) rd(a[4:0]);

    foreach (vecs[v]) begin
      address = vecs[v].addr; data = vecs[v].wdata; be = vecs[v].wbe; we = 1'b1;
      #1;
      chk("rdw_comb", data_out, vecs[v].old);
      rq.push_back(vecs[v].old);
      step();
      we = 1'b0;
      chk("rdw_reg", data_out_r, rq.pop_front());
      #1;
      chk("be_write", data_out, vecs[v].exp);
      model[vecs[v].addr] = vecs[v].exp;
    end

    done_cnt = 0;
    load_start = 1'b1; load_base = 5'd30; load_count = 6'd4;
    step();
    load_start = 1'b0;
    chk("load_ready_rise", {29'b0, load_ready, mem_ready, busy}, 32'b101);
    load_valid = 1'b1; load_data = 32'h10; address = 5'd5; data = '1; be = '1; we = 1'b1;
    step();
    we = 1'b0; load_data = 32'h11;
    step();
    load_valid = 1'b0;
    step(); step();
    chk("stall_load_ready", {31'b0, load_ready}, 32'd1);
    load_valid = 1'b1; load_data = 32'h12;
    step();
    chk("pre_done", {31'b0, load_done}, 32'd0);
    load_data = 32'h13;
    step();
    load_valid = 1'b0;
    chk("burst_done", {28'b0, load_done, mem_ready, load_ready, busy}, 32'b1100);
    chk("burst_done_r", {28'b0, load_done_r, mem_ready_r, load_ready_r, busy_r}, 32'b1100);
    step();
    chk("done_single", {31'b0, load_done}, 32'd0);
    chk("done_count", done_cnt, 32'd1);
    model[30] = 32'h10; model[31] = 32'h11; model[0] = 32'h12; model[1] = 32'h13;
    rd(5'd30); rd(5'd31); rd(5'd0); rd(5'd1); rd(5'd5);

    load_start = 1'b1; load_base = 5'd20; load_count = 6'd0;
    step();
    chk("zero_len_done", {30'b0, load_done, mem_ready}, 32'b11);
    load_base = 5'd10; load_count = 6'd2;
    step();
    load_start = 1'b0;
    chk("b2b_accept", {30'b0, load_ready, load_done}, 32'b10);
    load_valid = 1'b1; load_data = 32'hA0;
    step();
    load_data = 32'hA1;
    step();
    load_valid = 1'b0;
    chk("b2b_done", {31'b0, load_done}, 32'd1);
    model[10] = 32'hA0; model[11] = 32'hA1;
    rd(5'd20); rd(5'd10); rd(5'd11);

    load_start = 1'b1; load_base = 5'd0; load_count = 6'd40;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1; load_data = 32'h100 + i;
      step();
      model[i] = 32'h100 + i;
      if (i == 30) chk("clamp_not_done", {31'b0, load_done}, 32'd0);
    end
    load_valid = 1'b0;
    chk("clamp_done", {30'b0, load_done, mem_ready}, 32'b11);
    rd(5'd0); rd(5'd17); rd(5'd31);

    address = 5'd2;
    step();
    chk("rr_addr2", data_out_r, 32'h102);
    address = 5'd9;
    #1;
    chk("rr_hold", data_out_r, 32'h102);
    step();
    chk("rr_addr9", data_out_r, 32'h109);

    load_start = 1'b1; load_base = 5'd3; load_count = 6'd5;
    step();
    load_start = 1'b0; load_valid = 1'b1; load_data = 32'h50;
    step();
    load_data = 32'h51;
    step();
    done_snap = done_cnt;
    rst_n = 1'b0; load_valid = 1'b0;
    #1;
    chk("midrst_status", {29'b0, mem_ready, busy, load_ready}, 32'b010);
    chk("midrst_data_out_r", data_out_r, 32'h0);
    step();
    rst_n = 1'b1;
    init_sweep(1'b0);
    chk("midrst_no_done", done_cnt, done_snap);
    foreach (model[i]) model[i] = '0;
    for (int a = 0; a < 32; a++) rd(a[4:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
